// File: rtl/paint_sequencer.sv
// Frame sequencer: optional background clear, then one paint_element run per descriptor,
// muxed onto a single frame-buffer write port. Clear pass compiled in with PAINT_SEQ_CLEAR_EN.
module paint_sequencer #(
  parameter int         COOR_WIDTH   = 11,
  parameter int         IDX_WIDTH    = 4,
  parameter int         FRAME_WIDTH  = 800,
  parameter int         FRAME_HEIGHT = 600,
  parameter logic [1:0] BG_PALETTE   = 2'd0,
  parameter int         PIPE_SKIP    = 2
)(
  input  logic                  clk_33m,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [IDX_WIDTH:0]    elem_count,
  output logic [IDX_WIDTH-1:0]  elem_idx,
  input  logic [COOR_WIDTH-1:0] desc_sprite_x,
  input  logic [COOR_WIDTH-1:0] desc_sprite_y,
  input  logic [COOR_WIDTH-1:0] desc_frame_x,
  input  logic [COOR_WIDTH-1:0] desc_frame_y,
  input  logic [COOR_WIDTH-1:0] desc_width,
  input  logic [COOR_WIDTH-1:0] desc_height,
  output logic                  pe_start,
  output logic [COOR_WIDTH-1:0] pe_sprite_x,
  output logic [COOR_WIDTH-1:0] pe_sprite_y,
  output logic [COOR_WIDTH-1:0] pe_frame_x,
  output logic [COOR_WIDTH-1:0] pe_frame_y,
  output logic [COOR_WIDTH-1:0] pe_width,
  output logic [COOR_WIDTH-1:0] pe_height,
  input  logic [COOR_WIDTH-1:0] pe_write_x,
  input  logic [COOR_WIDTH-1:0] pe_write_y,
  input  logic [1:0]            pe_write_palette,
  input  logic                  pe_finished,
  output logic                  fb_we,
  output logic [COOR_WIDTH-1:0] fb_x,
  output logic [COOR_WIDTH-1:0] fb_y,
  output logic [1:0]            fb_palette,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_START, S_PAINT, S_ADVANCE, S_DONE
  } state_t;

  localparam int                   SKW  = (PIPE_SKIP < 1) ? 1 : $clog2(PIPE_SKIP + 1);
  localparam logic [IDX_WIDTH:0]   MAXN = {1'b1, {IDX_WIDTH{1'b0}}};
  localparam logic [COOR_WIDTH-1:0] XLIM = COOR_WIDTH'(FRAME_WIDTH);
  localparam logic [COOR_WIDTH-1:0] YLIM = COOR_WIDTH'(FRAME_HEIGHT);

  state_t                r_state, w_next;
  logic [IDX_WIDTH:0]    r_n;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [SKW-1:0]        r_skip;
  logic                  r_overrun;
  logic [COOR_WIDTH-1:0] r_sx, r_sy, r_fx, r_fy, r_w, r_h;
  logic [IDX_WIDTH:0]    w_n_in;
  logic                  w_last_elem, w_skip_zero, w_in_frame;

`ifdef PAINT_SEQ_CLEAR_EN
  localparam logic [COOR_WIDTH-1:0] XMAX = COOR_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COOR_WIDTH-1:0] YMAX = COOR_WIDTH'(FRAME_HEIGHT - 1);
  logic [COOR_WIDTH-1:0] r_cx, r_cy;
  logic                  w_clear_last;
  assign w_clear_last = (r_cx == XMAX) && (r_cy == YMAX);
`else
  logic [1:0] w_unused_bg;
  assign w_unused_bg = BG_PALETTE;
`endif

  assign w_n_in      = (elem_count > MAXN) ? MAXN : elem_count;
  assign w_last_elem = (({1'b0, r_idx} + 1'b1) == r_n);
  assign w_skip_zero = (r_skip == '0);
  assign w_in_frame  = (pe_write_x < XLIM) && (pe_write_y < YLIM);

  assign elem_idx      = r_idx;
  assign busy          = (r_state != S_IDLE);
  assign frame_overrun = r_overrun;
  assign pe_sprite_x   = r_sx;
  assign pe_sprite_y   = r_sy;
  assign pe_frame_x    = r_fx;
  assign pe_frame_y    = r_fy;
  assign pe_width      = r_w;
  assign pe_height     = r_h;

  always_ff @(posedge clk_33m or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    pe_start   = 1'b0;
    fb_we      = 1'b0;
    fb_x       = '0;
    fb_y       = '0;
    fb_palette = 2'd0;
    frame_done = 1'b0;
    case (r_state)
`ifdef PAINT_SEQ_CLEAR_EN
      S_IDLE: if (frame_start) w_next = S_CLEAR;
      S_CLEAR: begin
        fb_we      = 1'b1;
        fb_x       = r_cx;
        fb_y       = r_cy;
        fb_palette = BG_PALETTE;
        if (w_clear_last) w_next = (r_n != '0) ? S_FETCH : S_DONE;
      end
`else
      S_IDLE: if (frame_start) w_next = (w_n_in != '0) ? S_FETCH : S_DONE;
`endif
      S_FETCH:
        w_next = ((desc_width == '0) || (desc_height == '0)) ? S_ADVANCE : S_START;
      S_START: begin
        pe_start = 1'b1;
        w_next   = S_PAINT;
      end
      S_PAINT: begin
        // palette 0 is transparent; off-frame pixels are dropped rather than wrapped
        fb_x       = pe_write_x;
        fb_y       = pe_write_y;
        fb_palette = pe_write_palette;
        fb_we      = w_skip_zero && !pe_finished && (pe_write_palette != 2'd0) && w_in_frame;
        if (w_skip_zero && pe_finished) w_next = S_ADVANCE;
      end
      S_ADVANCE: w_next = w_last_elem ? S_DONE : S_FETCH;
      S_DONE: begin
        frame_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_idx     <= '0;
      r_skip    <= '0;
      r_overrun <= 1'b0;
      r_sx      <= '0;
      r_sy      <= '0;
      r_fx      <= '0;
      r_fy      <= '0;
      r_w       <= '0;
      r_h       <= '0;
`ifdef PAINT_SEQ_CLEAR_EN
      r_cx      <= '0;
      r_cy      <= '0;
`endif
    end else begin
      r_overrun <= frame_start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: if (frame_start) begin
          r_n   <= w_n_in;
          r_idx <= '0;
`ifdef PAINT_SEQ_CLEAR_EN
          r_cx  <= '0;
          r_cy  <= '0;
`endif
        end
`ifdef PAINT_SEQ_CLEAR_EN
        S_CLEAR: begin
          if (r_cx == XMAX) begin
            r_cx <= '0;
            r_cy <= r_cy + 1'b1;
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
`endif
        S_FETCH: begin
          r_sx <= desc_sprite_x;
          r_sy <= desc_sprite_y;
          r_fx <= desc_frame_x;
          r_fy <= desc_frame_y;
          r_w  <= desc_width;
          r_h  <= desc_height;
        end
        S_START: r_skip <= SKW'(PIPE_SKIP);
        S_PAINT: if (!w_skip_zero) r_skip <= r_skip - 1'b1;
        S_ADVANCE: if (!w_last_elem) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_sequencer.sv
// Scoreboard bench for paint_sequencer on an 8x4 frame with a behavioural paint engine.
module tb_paint_sequencer;
  localparam int CW = 11;
  localparam int IW = 4;
`ifdef PAINT_SEQ_CLEAR_EN
  localparam int CLR = 32;
`else
  localparam int CLR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [IW:0]   elem_count = '0;
  logic [IW-1:0] elem_idx;
  logic [CW-1:0] desc_sprite_x, desc_sprite_y, desc_frame_x, desc_frame_y, desc_width, desc_height;
  logic          pe_start;
  logic [CW-1:0] pe_sprite_x, pe_sprite_y, pe_frame_x, pe_frame_y, pe_width, pe_height;
  logic [CW-1:0] pe_write_x, pe_write_y;
  logic [1:0]    pe_write_palette;
  logic          pe_finished;
  logic          fb_we;
  logic [CW-1:0] fb_x, fb_y;
  logic [1:0]    fb_palette;
  logic          busy, frame_done, frame_overrun;

  always #5 clk = ~clk;

  paint_sequencer #(.COOR_WIDTH(CW), .IDX_WIDTH(IW), .FRAME_WIDTH(8), .FRAME_HEIGHT(4),
                    .BG_PALETTE(2'd0), .PIPE_SKIP(2)) dut (
    .clk_33m(clk), .rst_n(rst_n), .frame_start(frame_start), .elem_count(elem_count),
    .elem_idx(elem_idx),
    .desc_sprite_x(desc_sprite_x), .desc_sprite_y(desc_sprite_y),
    .desc_frame_x(desc_frame_x), .desc_frame_y(desc_frame_y),
    .desc_width(desc_width), .desc_height(desc_height),
    .pe_start(pe_start),
    .pe_sprite_x(pe_sprite_x), .pe_sprite_y(pe_sprite_y),
    .pe_frame_x(pe_frame_x), .pe_frame_y(pe_frame_y),
    .pe_width(pe_width), .pe_height(pe_height),
    .pe_write_x(pe_write_x), .pe_write_y(pe_write_y),
    .pe_write_palette(pe_write_palette), .pe_finished(pe_finished),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_palette(fb_palette),
    .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
  );

  // descriptor table, read combinationally
  logic [CW-1:0] t_sx[16], t_sy[16], t_fx[16], t_fy[16], t_w[16], t_h[16];
  logic [31:0]   t_pat[16];
  assign desc_sprite_x = t_sx[elem_idx];
  assign desc_sprite_y = t_sy[elem_idx];
  assign desc_frame_x  = t_fx[elem_idx];
  assign desc_frame_y  = t_fy[elem_idx];
  assign desc_width    = t_w[elem_idx];
  assign desc_height   = t_h[elem_idx];

  // paint engine: two junk cycles after start, then one pixel per cycle in raster order
  int          pe_dly, pe_k, npx;
  logic [31:0] pat_sh;
  always_comb begin
    npx              = int'(pe_width) * int'(pe_height);
    pat_sh           = t_pat[elem_idx] >> (2 * pe_k);
    pe_write_x       = '0;
    pe_write_y       = '0;
    pe_write_palette = 2'd3;
    pe_finished      = 1'b0;
    if (pe_dly > 0) begin
      pe_finished = 1'b0;
    end else if (pe_k < npx) begin
      pe_write_x       = pe_frame_x + CW'(pe_k % int'(pe_width));
      pe_write_y       = pe_frame_y + CW'(pe_k / int'(pe_width));
      pe_write_palette = pat_sh[1:0];
    end else begin
      pe_finished = 1'b1;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_dly <= 0;
      pe_k   <= 0;
    end else if (pe_start) begin
      pe_dly <= 2;
      pe_k   <= 0;
    end else if (pe_dly > 0) begin
      pe_dly <= pe_dly - 1;
    end else if (pe_k < npx) begin
      pe_k <= pe_k + 1;
    end
  end

  int    checks = 0, errors = 0;
  string tname = "reset";
  logic [23:0] exp_q[$];
  logic [IW-1:0] idx_log[$];
  int cyc = 0, fs_cyc = 0, done_cyc = 0;
  int n_done = 0, n_pe = 0, n_ovr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0h expected=%0h", tname, nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every frame-buffer write
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (frame_start && !busy) fs_cyc = cyc;
      if (pe_start) n_pe++;
      if (frame_overrun) n_ovr++;
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (busy && (idx_log.size() == 0 || idx_log[idx_log.size()-1] != elem_idx))
        idx_log.push_back(elem_idx);
      if (fb_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s/unexpected_write x=%0d y=%0d pal=%0d", tname, fb_x, fb_y, fb_palette);
        end else begin
          chk("fb_write{x,y,pal}", {8'h0, fb_x, fb_y, fb_palette}, {8'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic push_w(input int x, input int y, input int p);
    exp_q.push_back({CW'(x), CW'(y), 2'(p)});
  endtask

  task automatic push_clear();
    if (CLR > 0)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 8; x++) push_w(x, y, 0);
  endtask

  task automatic set_desc(input int i, input int fx, input int fy, input int w, input int h,
                          input logic [31:0] pat);
    t_sx[i] = CW'(i); t_sy[i] = CW'(i);
    t_fx[i] = CW'(fx); t_fy[i] = CW'(fy);
    t_w[i] = CW'(w); t_h[i] = CW'(h);
    t_pat[i] = pat;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fire(input int cnt);
    tick(1);
    frame_start = 1'b1;
    elem_count  = (IW+1)'(cnt);
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic end_frame(input int d0, input int p0, input int dt, input int pexp);
    int i;
    i = 0;
    while (n_done == d0 && i < 600) begin
      tick(1);
      i++;
    end
    tick(3);
    chk("frame_done_count", n_done - d0, 1);
    chk("done_latency", done_cyc - fs_cyc, dt);
    chk("pe_start_count", n_pe - p0, pexp);
    chk("writes_outstanding", exp_q.size(), 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int d0, p0, o0;
    logic found;
    for (int i = 0; i < 16; i++) set_desc(i, 0, 0, 0, 0, 32'h0);

    #12;
    chk("fb_we", fb_we, 0);
    chk("busy", busy, 0);
    chk("frame_done", frame_done, 0);
    chk("pe_start", pe_start, 0);
    chk("elem_idx", elem_idx, 0);
    chk("fb_xy_pal", {fb_x, fb_y, fb_palette}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    tname = "empty_frame";
    push_clear();
    d0 = n_done; p0 = n_pe;
    fire(0);
    end_frame(d0, p0, 1 + CLR, 0);

    tname = "one_2x2";
    set_desc(0, 1, 1, 2, 2, 32'hFF);
    push_clear();
    push_w(1, 1, 3); push_w(2, 1, 3); push_w(1, 2, 3); push_w(2, 2, 3);
    d0 = n_done; p0 = n_pe;
    fire(1);
    end_frame(d0, p0, 11 + CLR, 1);

    tname = "transparent_offframe";
    set_desc(0, 0, 0, 2, 2, 32'h81);
    set_desc(1, 7, 3, 2, 2, 32'hFF);
    push_clear();
    push_w(0, 0, 1); push_w(1, 1, 2); push_w(7, 3, 3);
    d0 = n_done; p0 = n_pe;
    fire(2);
    end_frame(d0, p0, 21 + CLR, 2);

    tname = "skip_zero_width";
    set_desc(0, 4, 0, 1, 1, 32'h3);
    set_desc(1, 0, 0, 0, 2, 32'hFF);
    set_desc(2, 5, 1, 1, 2, 32'h6);
    push_clear();
    push_w(4, 0, 3); push_w(5, 1, 2); push_w(5, 2, 1);
    idx_log.delete();
    d0 = n_done; p0 = n_pe;
    fire(3);
    end_frame(d0, p0, 18 + CLR, 2);
    chk("idx_seq_len", idx_log.size(), 3);
    if (idx_log.size() == 3) begin
      chk("idx_seq0", idx_log[0], 0);
      chk("idx_seq1", idx_log[1], 1);
      chk("idx_seq2", idx_log[2], 2);
    end

    tname = "overrun";
    set_desc(0, 1, 1, 2, 2, 32'hFF);
    push_clear();
    push_w(1, 1, 3); push_w(2, 1, 3); push_w(1, 2, 3); push_w(2, 2, 3);
    d0 = n_done; p0 = n_pe; o0 = n_ovr;
    fire(1);
    tick(1);
    fire(0);
    end_frame(d0, p0, 11 + CLR, 1);
    chk("overrun_count", n_ovr - o0, 1);

    tname = "reset_mid_paint";
    set_desc(0, 0, 0, 4, 4, 32'hFFFF_FFFF);
    push_clear();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) push_w(x, y, 3);
    d0 = n_done;
    fire(1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (pe_start) found = 1'b1;
    end
    chk("pe_start_seen", found, 1);
    tick(4);
    chk("fb_we_in_paint", fb_we, 1);
    rst_n = 1'b0;
    #1;
    chk("fb_we_async", fb_we, 0);
    chk("busy_async", busy, 0);
    chk("pe_width_reset", pe_width, 0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("no_done_after_abort", n_done - d0, 0);

    tname = "redraw";
    set_desc(0, 1, 1, 2, 2, 32'hFF);
    push_clear();
    push_w(1, 1, 3); push_w(2, 1, 3); push_w(1, 2, 3); push_w(2, 2, 3);
    d0 = n_done; p0 = n_pe;
    fire(1);
    end_frame(d0, p0, 11 + CLR, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog/timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
